watch_ctrl: RTL

- Mode/set controller that sequences the watch_op counter datapath.
- Owns the watch_op run enable and tick threshold.
- Runs a button-driven FSM so the user can stop the watch, edit hour/min/sec in shadow registers, and commit them with a one-cycle load pulse.
- Also generates the blink indicator used by the display path for the field being edited.

---
 rtl/watch_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/watch_ctrl.sv
// Mode/set controller for the watch_op counter datapath.
// A button-driven FSM stops the watch and lets the user edit hour/min/sec
// in shadow registers. Committing raises a one-cycle load strobe, and a
// blink phase is produced for the field being edited.
module watch_ctrl #(
   parameter int CNT_BIT  = 32,
   parameter int SEC_BIT  = 6,
   parameter int MIN_BIT  = 6,
   parameter int HOUR_BIT = 6,
   parameter int CNT_TH   = 100000000,
   parameter int BLINK_TH = 50000000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_btn_mode,
   input  logic                i_btn_up,
   input  logic                i_btn_down,
   input  logic                i_btn_cancel,
   input  logic [SEC_BIT-1:0]  i_sec,
   input  logic [MIN_BIT-1:0]  i_min,
   input  logic [HOUR_BIT-1:0] i_hour,
   output logic                o_run_en,
   output logic [CNT_BIT-1:0]  o_cnt_th,
   output logic                o_load,
   output logic [SEC_BIT-1:0]  o_set_sec,
   output logic [MIN_BIT-1:0]  o_set_min,
   output logic [HOUR_BIT-1:0] o_set_hour,
   output logic [2:0]          o_state,
   output logic                o_blink
);

   localparam int BLINK_W = (BLINK_TH > 1) ? $clog2(BLINK_TH) : 1;
   localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TH - 1);
   localparam logic [31:0] HOUR_MAX = 32'd23;
   localparam logic [31:0] MS_MAX   = 32'd59;

   typedef enum logic [2:0] {
      ST_RUN      = 3'd0,
      ST_SET_HOUR = 3'd1,
      ST_SET_MIN  = 3'd2,
      ST_SET_SEC  = 3'd3,
      ST_LOAD     = 3'd4
   } state_t;

   state_t               state_reg, state_next;
   logic                 run_en_reg, run_en_next;
   logic                 load_reg, load_next;
   logic [HOUR_BIT-1:0]  hour_reg, hour_next;
   logic [MIN_BIT-1:0]   min_reg, min_next;
   logic [SEC_BIT-1:0]   sec_reg, sec_next;
   logic [BLINK_W-1:0]   blink_cnt_reg, blink_cnt_next;
   logic                 blink_reg, blink_next;

   logic                 edit_req;
   logic                 edit_up;
   logic                 edit_done;
   logic                 set_cur;
   logic                 set_nxt;

   // Up/down wrap: an up at or beyond the maximum goes to 0, a down from 0
   // or from an out-of-range captured value lands on the maximum.
   function automatic logic [31:0] step_field(input logic [31:0] val,
                                              input logic [31:0] max_val,
                                              input logic        dir_up);
      logic [31:0] res;
      if (dir_up) begin
         res = (val >= max_val) ? 32'd0 : val + 32'd1;
      end else begin
         res = ((val == 32'd0) || (val > max_val)) ? max_val : val - 32'd1;
      end
      return res;
   endfunction

   assign edit_req = i_btn_up ^ i_btn_down;
   assign edit_up  = i_btn_up;

   // Next-state, shadow edits and blink sequencing; cancel > mode > up/down.
   always_comb begin
      state_next     = state_reg;
      hour_next      = hour_reg;
      min_next       = min_reg;
      sec_next       = sec_reg;
      edit_done      = 1'b0;
      blink_cnt_next = blink_cnt_reg;
      blink_next     = blink_reg;

      case (state_reg)
         ST_RUN: begin
            if (!i_btn_cancel && i_btn_mode) begin
               state_next = ST_SET_HOUR;
               hour_next  = i_hour;
               min_next   = i_min;
               sec_next   = i_sec;
            end
         end
         ST_SET_HOUR: begin
            if (i_btn_cancel) begin
               state_next = ST_RUN;
            end else if (i_btn_mode) begin
               state_next = ST_SET_MIN;
            end else if (edit_req) begin
               hour_next = HOUR_BIT'(step_field(32'(hour_reg), HOUR_MAX, edit_up));
               edit_done = 1'b1;
            end
         end
         ST_SET_MIN: begin
            if (i_btn_cancel) begin
               state_next = ST_RUN;
            end else if (i_btn_mode) begin
               state_next = ST_SET_SEC;
            end else if (edit_req) begin
               min_next  = MIN_BIT'(step_field(32'(min_reg), MS_MAX, edit_up));
               edit_done = 1'b1;
            end
         end
         ST_SET_SEC: begin
            if (i_btn_cancel) begin
               state_next = ST_RUN;
            end else if (i_btn_mode) begin
               state_next = ST_LOAD;
            end else if (edit_req) begin
               sec_next  = SEC_BIT'(step_field(32'(sec_reg), MS_MAX, edit_up));
               edit_done = 1'b1;
            end
         end
         ST_LOAD: begin
            state_next = ST_RUN;
         end
         default: begin
            state_next = ST_RUN;
         end
      endcase

      set_cur = (state_reg == ST_SET_HOUR) || (state_reg == ST_SET_MIN) ||
                (state_reg == ST_SET_SEC);
      set_nxt = (state_next == ST_SET_HOUR) || (state_next == ST_SET_MIN) ||
                (state_next == ST_SET_SEC);

      if (state_next != state_reg) begin
         blink_cnt_next = '0;
         blink_next     = set_nxt;
      end else if (edit_done) begin
         // Restart the phase so the freshly edited field shows solid.
         blink_cnt_next = '0;
         blink_next     = 1'b1;
      end else if (set_cur) begin
         if (blink_cnt_reg == BLINK_LAST) begin
            blink_cnt_next = '0;
            blink_next     = ~blink_reg;
         end else begin
            blink_cnt_next = blink_cnt_reg + BLINK_W'(1);
         end
      end else begin
         blink_cnt_next = '0;
         blink_next     = 1'b0;
      end

      run_en_next = (state_next == ST_RUN);
      load_next   = (state_next == ST_LOAD);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_RUN;
      end else begin
         state_reg <= state_next;
      end
   end

   // Registered outputs, shadow fields and blink counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         run_en_reg    <= 1'b1;
         load_reg      <= 1'b0;
         hour_reg      <= '0;
         min_reg       <= '0;
         sec_reg       <= '0;
         blink_cnt_reg <= '0;
         blink_reg     <= 1'b0;
      end else begin
         run_en_reg    <= run_en_next;
         load_reg      <= load_next;
         hour_reg      <= hour_next;
         min_reg       <= min_next;
         sec_reg       <= sec_next;
         blink_cnt_reg <= blink_cnt_next;
         blink_reg     <= blink_next;
      end
   end

   assign o_state    = state_reg;
   assign o_run_en   = run_en_reg;
   assign o_load     = load_reg;
   assign o_set_hour = hour_reg;
   assign o_set_min  = min_reg;
   assign o_set_sec  = sec_reg;
   assign o_blink    = blink_reg;
   assign o_cnt_th   = CNT_BIT'(CNT_TH);

endmodule
